// File: rtl/ps2_pkg.sv
// Shared constants and helpers for the PS/2 keyboard receiver.
package ps2_pkg;

  // A device-to-host frame: start, 8 data bits (LSB first), odd parity, stop.
  localparam int PS2_FRAME_BITS  = 11;
  localparam int PS2_BYTE_W      = 8;
  localparam int PS2_SYNC_STAGES = 3;
  localparam int PS2_FIFO_DEPTH  = 8;

  // Bits held in the frame buffer when the stop bit arrives (start..parity).
  localparam int PS2_BUF_BITS = PS2_FRAME_BITS - 1;

  // Position of the final (stop) bit in the 4-bit bit counter.
  localparam logic [3:0] PS2_LAST_BIT = 4'(PS2_FRAME_BITS - 1);

  // True when the data byte plus its parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [PS2_BYTE_W:0] data_and_parity);
    return ^data_and_parity;
  endfunction

endpackage : ps2_pkg

// File: rtl/ps2_rx_fifo.sv
// Count-based synchronous FIFO for received scan-code bytes.
// The head byte is presented combinationally and reads as zero when empty.
// A push while full with no simultaneous pop drops the byte and sets a sticky
// overflow flag, which clears only on reset.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = PS2_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        clrn,
  input  logic                        push,
  input  logic [PS2_BYTE_W-1:0]       push_data,
  input  logic                        pop,
  output logic [PS2_BYTE_W-1:0]       head,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [PS2_BYTE_W-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  full;
  logic                  empty;
  logic                  do_push;
  logic                  do_pop;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // A pop frees a slot in the same cycle, so a full FIFO may still accept a push.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer, occupancy and overflow bookkeeping.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  // Storage array write port.
  // NOTE: the data array has no reset; empty slots are never observed because
  // the head is masked while count is zero, so resetting them would only add logic.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule : ps2_rx_fifo

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises the keyboard clock/data pins, deframes
// 11-bit device-to-host frames and buffers valid scan-code bytes in a FIFO
// read through a ready / nextdata_n (falling-edge pop) handshake.
// Build option: define PS2_PARITY_CHECK_EN to discard frames with bad odd
// parity; otherwise only the start and stop bits gate acceptance.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = PS2_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
  input  logic                  nextdata_n,
  output logic [PS2_BYTE_W-1:0] data,
  output logic                  ready,
  output logic                  overflow
);

  logic [PS2_SYNC_STAGES-1:0]  clk_sync;
  logic [1:0]                  data_sync;
  logic                        ps2_fall;
  logic                        ps2_bit;
  logic [PS2_BUF_BITS-1:0]     frame_buf;
  logic [3:0]                  bit_cnt;
  logic                        frame_done;
  logic                        start_ok;
  logic                        stop_ok;
  logic                        parity_ok;
  logic                        push;
  logic                        nd_prev;
  logic                        pop;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  // Pin synchronisers; idle bus is high, so they reset to 1 to avoid a false edge.
  // NOTE: sequential state uses non-blocking assignments so every flop in the
  // chain samples the value its predecessor held before this clock edge.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[PS2_SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // Falling edge: the oldest stage still high while the next one is already low.
  assign ps2_fall = clk_sync[PS2_SYNC_STAGES-1] & ~clk_sync[PS2_SYNC_STAGES-2];
  assign ps2_bit  = data_sync[1];

  // Frame checks, evaluated while the stop bit is being sampled.
  assign frame_done = ps2_fall && (bit_cnt == PS2_LAST_BIT);
  assign start_ok   = ~frame_buf[0];
  assign stop_ok    = ps2_bit;
`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok  = odd_parity_ok(frame_buf[PS2_BUF_BITS-1:1]);
`else
  // Parity is still computed so the stored bit has a reader, but never rejects.
  assign parity_ok  = odd_parity_ok(frame_buf[PS2_BUF_BITS-1:1]) | 1'b1;
`endif
  assign push       = frame_done & start_ok & stop_ok & parity_ok;

  // Deframer: shift bits in LSB first; the stop edge ends the frame either way.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      frame_buf <= '0;
      bit_cnt   <= '0;
    end else if (ps2_fall) begin
      if (bit_cnt == PS2_LAST_BIT) begin
        bit_cnt <= '0;
      end else begin
        frame_buf <= {ps2_bit, frame_buf[PS2_BUF_BITS-1:1]};
        bit_cnt   <= bit_cnt + 1'b1;
      end
    end
  end

  // Previous nextdata_n level, for detecting the high-to-low read request.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) nd_prev <= 1'b1;
    else       nd_prev <= nextdata_n;
  end

  assign pop   = nd_prev & ~nextdata_n & ready;
  assign ready = (fifo_count != '0);

  ps2_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .clrn      (clrn),
    .push      (push),
    .push_data (frame_buf[PS2_BYTE_W:1]),
    .pop       (pop),
    .head      (data),
    .count     (fifo_count),
    .overflow  (overflow)
  );

endmodule : ps2_keyboard_rx

// File: tb/tb_ps2_keyboard_rx.sv
// Directed testbench for ps2_keyboard_rx: drives PS/2 frames bit by bit and
// checks the FIFO handshake against hand-computed expectations.
module tb_ps2_keyboard_rx;

  localparam int HALF = 20;  // system clocks per PS/2 clock half-period

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  ps2_keyboard_rx #(.FIFO_DEPTH(8)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Send the first n bits of an 11-bit frame, bit 0 first.
  task automatic send_bits(input logic [10:0] frame, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = frame[i];
      wait_clks(HALF);
      ps2_clk = 1'b0;
      wait_clks(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_clks(HALF);
  endtask

  // Full frame with correct odd parity unless flipped, and selectable stop bit.
  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop);
    logic par;
    par = ~(^b) ^ par_flip;
    send_bits({stop, par, b, 1'b0}, 11);
  endtask

  task automatic pop_pulse(input int low_cycles);
    @(negedge clk);
    nextdata_n = 1'b0;
    wait_clks(low_cycles);
    nextdata_n = 1'b1;
    wait_clks(2);
  endtask

  initial begin
    wait_clks(3);
    check("reset_ready", ready, 1'b0);
    check("reset_data", data, 8'h00);
    check("reset_ovf", overflow, 1'b0);
    clrn = 1'b1;
    wait_clks(5);

    // Single frame, then one pop from a two-cycle low pulse.
    send_frame(8'h1C, 1'b0, 1'b1);
    check("f1_ready", ready, 1'b1);
    check("f1_data", data, 8'h1C);
    check("f1_ovf", overflow, 1'b0);
    pop_pulse(2);
    check("f1_pop_ready", ready, 1'b0);
    check("f1_pop_data", data, 8'h00);

    // Three back-to-back frames read in order.
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    check("seq_data0", data, 8'h1C);
    pop_pulse(1);
    check("seq_data1", data, 8'hF0);
    pop_pulse(1);
    check("seq_data2", data, 8'h1C);
    pop_pulse(1);
    check("seq_empty", ready, 1'b0);

    // Nine frames into an eight-deep FIFO.
    for (int i = 0; i < 8; i++) send_frame(8'h1B, 1'b0, 1'b1);
    check("full_no_ovf", overflow, 1'b0);
    send_frame(8'h1B, 1'b0, 1'b1);
    check("ovf_set", overflow, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ovf_ready%0d", i), ready, 1'b1);
      check($sformatf("ovf_data%0d", i), data, 8'h1B);
      pop_pulse(1);
    end
    check("ovf_drained", ready, 1'b0);
    check("ovf_sticky", overflow, 1'b1);

    // Bad parity frame.
    send_frame(8'h1C, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    check("par_drop", ready, 1'b0);
    send_frame(8'h1B, 1'b0, 1'b1);
    check("par_next", data, 8'h1B);
`else
    check("par_ignored", data, 8'h1C);
`endif
    pop_pulse(1);
    check("par_empty", ready, 1'b0);

    // Stop bit 0 frame is discarded; next frame accepted.
    send_frame(8'h1C, 1'b0, 1'b0);
    check("stop_drop", ready, 1'b0);
    send_frame(8'h1B, 1'b0, 1'b1);
    check("stop_next", data, 8'h1B);
    pop_pulse(1);
    check("stop_empty", ready, 1'b0);

    // Reset after five bits of a frame, then a clean frame.
    send_bits({1'b1, 1'b1, 8'h1B, 1'b0}, 5);
    clrn = 1'b0;
    wait_clks(3);
    check("mid_rst_ovf", overflow, 1'b0);
    clrn = 1'b1;
    wait_clks(5);
    send_frame(8'h1B, 1'b0, 1'b1);
    check("mid_ready", ready, 1'b1);
    check("mid_data", data, 8'h1B);
    check("mid_ovf", overflow, 1'b0);
    pop_pulse(1);
    check("mid_one_byte", ready, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_ps2_keyboard_rx
